// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the shared add-shift multiplier arbiter.
package mult_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Never returns less than 1 so one-entry ranges still get a legal vector.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result == 0) begin
            result = 1;
        end else begin
            result = result;
        end
        return result;
    endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// Requester-side bundle of the shared multiplier: requests/operands in,
// grant/busy/done/product back.
interface mult_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       Req;
    logic [NUM_REQ*WIDTH-1:0] Opa;
    logic [NUM_REQ*WIDTH-1:0] Opb;
    logic [NUM_REQ-1:0]       Grant;
    logic                     Busy;
    logic [NUM_REQ-1:0]       Done;
    logic [2*WIDTH-1:0]       Product;

    modport master (output Req, Opa, Opb, input Grant, Busy, Done, Product);
    modport slave  (input Req, Opa, Opb, output Grant, Busy, Done, Product);
endinterface

// File: rtl/mult_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer,
// wrapping around, returned both one-hot and as an index.
module mult_rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PW      = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PW-1:0]      idx_o
);

    logic [PW:0] pos_s;
    logic        found_s;

    // Scan NUM_REQ positions starting at the pointer; keep the first hit.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        pos_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos_s = {1'b0, ptr_i} + (PW+1)'(k);
            if (pos_s >= (PW+1)'(NUM_REQ)) begin
                pos_s = pos_s - (PW+1)'(NUM_REQ);
            end else begin
                pos_s = pos_s;
            end
            if (!found_s && req_i[pos_s[PW-1:0]]) begin
                found_s = 1'b1;
                idx_o   = pos_s[PW-1:0];
                gnt_o[pos_s[PW-1:0]] = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shared signed add-shift multiplier with round-robin arbitration.
// Optional MULT_ARB_SKIP_ADD_EN: bypass ADD when the current multiplier bit is 0.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    mult_arbiter_if.slave bus
);

    localparam int PW = clog2(NUM_REQ);
    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               busy_q, busy_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      win_q, win_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               x_q, x_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    logic [NUM_REQ-1:0] arb_gnt_s;
    logic [PW-1:0]      arb_idx_s;
    logic [WIDTH:0]     sum_s;
    logic [WIDTH-1:0]   opa_arr_s [NUM_REQ];
    logic [WIDTH-1:0]   opb_arr_s [NUM_REQ];

    mult_rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_rr (
        .req_i (bus.Req),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s)
    );

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign opa_arr_s[g] = bus.Opa[g*WIDTH +: WIDTH];
        assign opb_arr_s[g] = bus.Opb[g*WIDTH +: WIDTH];
    end

    // Sign-extended adder; the last iteration subtracts because the top
    // multiplier bit carries negative weight.
    always_comb begin
        if (cnt_q == LAST_CNT) begin
            sum_s = {a_q[WIDTH-1], a_q} - {s_q[WIDTH-1], s_q};
        end else begin
            sum_s = {a_q[WIDTH-1], a_q} + {s_q[WIDTH-1], s_q};
        end
    end

    // Next-state and datapath updates for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (|bus.Req) begin
                    grant_d = arb_gnt_s;
                    win_d   = arb_idx_s;
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                s_d   = opa_arr_s[win_q];
                b_d   = opb_arr_s[win_q];
                a_d   = '0;
                x_d   = 1'b0;
                cnt_d = '0;
                if (win_q == PW'(NUM_REQ - 1)) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = win_q + PW'(1);
                end
`ifdef MULT_ARB_SKIP_ADD_EN
                state_d = b_d[0] ? ADD : SHIFT;
`else
                state_d = ADD;
`endif
            end
            ADD: begin
                if (b_q[0]) begin
                    {x_d, a_d} = sum_s;
                end else begin
                    x_d = x_q;
                end
                state_d = SHIFT;
            end
            SHIFT: begin
                a_d   = {x_q, a_q[WIDTH-1:1]};
                b_d   = {a_q[0], b_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
`ifdef MULT_ARB_SKIP_ADD_EN
                    state_d = b_d[0] ? ADD : SHIFT;
`else
                    state_d = ADD;
`endif
                end
            end
            DONE: begin
                prod_d  = {a_q, b_q};
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE) ? grant_d : '0;
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            win_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    assign bus.Grant   = grant_q;
    assign bus.Done    = done_q;
    assign bus.Busy    = busy_q;
    assign bus.Product = prod_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed table-driven bench for mult_arbiter (NUM_REQ=2, WIDTH=8).
module tb_mult_arbiter;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    mult_arbiter_if #(.NUM_REQ(2), .WIDTH(8)) bus ();

    mult_arbiter #(.NUM_REQ(2), .WIDTH(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] opa;
        logic [15:0] opb;
        logic [1:0]  grant;
        logic [15:0] prod;
        logic [1:0]  req_after;
        bit          mangle;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v);
        logic [7:0] sel_b;
        int         exp_lat;
        int         cyc;
        bit         got;
        bit         held_ok;
        sel_b = v.grant[1] ? v.opb[15:8] : v.opb[7:0];
`ifdef MULT_ARB_SKIP_ADD_EN
        exp_lat = 10 + $countones(sel_b);
`else
        exp_lat = 18;
`endif
        bus.Req = v.req;
        bus.Opa = v.opa;
        bus.Opb = v.opb;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (bus.Grant != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_grant", {30'd0, bus.Grant}, {30'd0, v.grant});
        if (!got) begin
            return;
        end
        got     = 1'b0;
        held_ok = 1'b1;
        cyc     = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clk);
            cyc = cyc + 1;
            if (bus.Grant != v.grant || bus.Busy != 1'b1) begin
                held_ok = 1'b0;
            end
            if (cyc == 1 && v.mangle) begin
                bus.Opa = 16'hA5A5;
                bus.Opb = 16'h5A5A;
                bus.Req = 2'b00;
            end
            if (bus.Done != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        check("grant_busy_held", {31'd0, held_ok}, 32'd1);
        check("latency", cyc + 1, exp_lat);
        check("done_onehot", {30'd0, bus.Done}, {30'd0, v.grant});
        bus.Req = v.req_after;
        @(negedge Clk);
        check("product", {16'd0, bus.Product}, {16'd0, v.prod});
        check("busy_after", {31'd0, bus.Busy}, 32'd0);
        check("grant_after", {30'd0, bus.Grant}, 32'd0);
        check("done_single", {30'd0, bus.Done}, 32'd0);
    endtask

    initial begin
        bit done_seen;
        checks = 0;
        errors = 0;
        //           req    opa       opb       grant  prod      after  mangle
        tbl[0]  = '{2'b11, 16'h0302, 16'h0504, 2'b01, 16'h0008, 2'b10, 1'b0};
        tbl[1]  = '{2'b10, 16'h0302, 16'h0504, 2'b10, 16'h000F, 2'b11, 1'b0};
        tbl[2]  = '{2'b11, 16'h0302, 16'h0504, 2'b01, 16'h0008, 2'b00, 1'b0};
        tbl[3]  = '{2'b01, 16'h0007, 16'h00FD, 2'b01, 16'hFFEB, 2'b00, 1'b0};
        tbl[4]  = '{2'b01, 16'h0080, 16'h0080, 2'b01, 16'h4000, 2'b00, 1'b0};
        tbl[5]  = '{2'b01, 16'h007F, 16'h0080, 2'b01, 16'hC080, 2'b00, 1'b0};
        tbl[6]  = '{2'b01, 16'h00FF, 16'h00FF, 2'b01, 16'h0001, 2'b00, 1'b0};
        tbl[7]  = '{2'b01, 16'h007F, 16'h007F, 2'b01, 16'h3F01, 2'b00, 1'b0};
        tbl[8]  = '{2'b10, 16'h0500, 16'h0600, 2'b10, 16'h001E, 2'b00, 1'b0};
        tbl[9]  = '{2'b10, 16'h0C00, 16'hF600, 2'b10, 16'hFF88, 2'b00, 1'b0};
        tbl[10] = '{2'b01, 16'h0023, 16'h0001, 2'b01, 16'h0023, 2'b00, 1'b0};
        tbl[11] = '{2'b01, 16'h0044, 16'h0000, 2'b01, 16'h0000, 2'b00, 1'b0};
        tbl[12] = '{2'b01, 16'h0000, 16'h0055, 2'b01, 16'h0000, 2'b00, 1'b0};
        tbl[13] = '{2'b01, 16'h0009, 16'h0003, 2'b01, 16'h001B, 2'b00, 1'b1};

        bus.Req = 2'b00;
        bus.Opa = 16'h0000;
        bus.Opb = 16'h0000;
        Reset   = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_grant", {30'd0, bus.Grant}, 32'd0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        check("rst_done", {30'd0, bus.Done}, 32'd0);
        check("rst_product", {16'd0, bus.Product}, 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        for (int t = 0; t < 14; t++) begin
            run_job(tbl[t]);
        end

        // Reset in the middle of a job: the job is dropped without a Done.
        bus.Req = 2'b01;
        bus.Opa = 16'h0011;
        bus.Opb = 16'h0022;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (bus.Grant != 2'b00) begin
                break;
            end
        end
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("midrst_busy", {31'd0, bus.Busy}, 32'd0);
        check("midrst_grant", {30'd0, bus.Grant}, 32'd0);
        check("midrst_product", {16'd0, bus.Product}, 32'd0);
        check("midrst_done", {30'd0, bus.Done}, 32'd0);
        Reset   = 1'b1;
        bus.Req = 2'b00;
        done_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (bus.Done != 2'b00) begin
                done_seen = 1'b1;
            end
        end
        check("midrst_no_done", {31'd0, done_seen}, 32'd0);
        run_job(tbl[3]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Shares one WIDTH-bit signed add-shift multiplier datapath among NUM_REQ requesters. Contains:
- a round-robin arbiter;
- the sequencing FSM (load, add/subtract, arithmetic shift);
- the A/B/X shift registers and the (WIDTH+1)-bit adder.

It sits between the switch/host-side requesters and the product display path. It returns a 2*WIDTH-bit signed product and a one-hot Done pulse to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- WIDTH, 8, operand width in bits; product is 2*WIDTH.

Ports:
- Clk  in  1  system clock, all logic on posedge.
- Reset  in  1  synchronous, active-low reset; Reset=0 at a posedge resets the block.
- Req  in  NUM_REQ  level request per requester.
- Opa  in  NUM_REQ*WIDTH  multiplicand S per requester; slice i = Opa[i*WIDTH +: WIDTH], two's complement.
- Opb  in  NUM_REQ*WIDTH  multiplier per requester, same slicing.
- Grant  out  NUM_REQ  one-hot; owner of current job, held from LOAD through DONE.
- Busy  out  1  high in every state except IDLE.
- Done  out  NUM_REQ  one-hot, single-cycle pulse in DONE to the granted requester.
- Product  out  2*WIDTH  {A,B} of the last completed job; held until the next DONE.

Behaviour:
- Reset (Reset=0 at a posedge), including mid-job:
  - state goes to IDLE; Grant, Done, Busy, Product, A, B, X, S cleared; RR pointer = 0.
  - The job is discarded and no Done is issued.
- States:
  - IDLE: if any Req bit is set, select the first set bit at or after the pointer, cyclically. Register the one-hot Grant and go to LOAD. Otherwise stay in IDLE.
  - LOAD: S <= Opa slice, B <= Opb slice of the winner; A <= 0; X <= 0; iteration count <= 0. Pointer <= (winner+1) mod NUM_REQ. Go to ADD.
  - ADD: if B[0]=1, {X,A} <= {A[W-1],A} + {S[W-1],S}. On the final iteration (count=WIDTH-1) it subtracts instead: {X,A} <= {A[W-1],A} - {S[W-1],S}. If B[0]=0, registers hold. Go to SHIFT.
  - SHIFT: arithmetic right shift of {X,A,B}: X holds, A <= {X,A[W-1:1]}, B <= {A[0],B[W-1:1]}. Then count++. If count was WIDTH-1, go to DONE; else go to ADD.
  - DONE: Product <= {A,B}; Done = Grant for this cycle only. Go to IDLE; Grant clears on entering IDLE.
- Latency:
  - Request accepted at edge k (IDLE→LOAD). Done is high in the cycle after edge k+2*WIDTH+1, i.e. Done is high 2*WIDTH+2 cycles after acceptance (18 for WIDTH=8).
  - Product is valid from the edge that ends DONE.
- Operands are sampled only in LOAD; later Opa/Opb changes are ignored.
- Req deasserted mid-job: the job still completes and Done still pulses.
- Requester release rule: a requester must drop Req before the posedge ending the IDLE cycle that follows its Done. A Req still high then is a new job; it is arbitrated against the others, so the pointer prevents starvation.
- No back-to-back DONE→LOAD; minimum job spacing is 2*WIDTH+3 cycles.
- Overflow cannot occur: a (WIDTH+1)-bit sum with sign extension is exact, and -2^(W-1) squared fits in 2*WIDTH signed bits.

Optional Feature:
- Macro MULT_ARB_SKIP_ADD_EN.
- Defined: from SHIFT (and from LOAD) the FSM enters ADD only when the next B[0]=1; otherwise it goes directly to SHIFT. Latency = 2 + WIDTH + popcount(Opb).
- Undefined: ADD is visited every iteration; latency is fixed at 2*WIDTH+2.
- Arithmetic results are identical in both builds.

Decomposition:
- Package mult_arb_pkg: state enum (IDLE, LOAD, ADD, SHIFT, DONE) and a count-width function clog2(WIDTH).
- One sub-module, mult_rr_arbiter: Req + pointer → one-hot winner, combinational. The pointer register stays in mult_arbiter.
- Datapath registers and the adder stay in the top module.

Test Plan:
- WIDTH=8: Req=01, Opa0=7, Opb0=0xFD (-3) → Done=01 exactly 18 cycles after acceptance; Product=0xFFEB (-21); Grant=01 throughout; Busy low after.
- Opa0=0x80, Opb0=0x80 → Product=0x4000. Opa0=0x7F, Opb0=0x80 → Product=0xC080.
- Req=11 first after reset → job 0 completes first. Then, with Req1 still high, job 1 is granted (Grant=10). Then both Req high again → requester 0 wins (pointer wraps).
- Reset=0 at cycle 6 of a job → next cycle: IDLE, Busy=0, Grant=0, Product=0, and no Done pulse ever appears for that job.
- Change Opa0/Opb0 and drop Req0 the cycle after LOAD → Product unchanged from the original operands; Done still pulses.
- With MULT_ARB_SKIP_ADD_EN: Opb=0x01 → Done 11 cycles after acceptance; Opb=0x00 → 10 cycles, Product=0. Without the macro, both take 18 cycles.
